csr_trap_seq: RTL

- CSR-side trap sequencer: the initiator that drives the machine-mode CSR register file's single write port and its read port.
- On a trap it writes mepc, mcause, mtval and mstatus in order, then reads mtvec and issues a PC redirect.
- On mret it restores mstatus, then reads mepc and issues a PC redirect.
- Sits between the pipeline's exception/commit logic and the CSR register file.

---
 rtl/csr_trap_seq.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/csr_trap_seq.sv
// rtl/csr_trap_seq.sv - machine-mode trap/mret sequencer driving the CSR register file
//
// Build option: CSR_TRAP_VECTORED_EN enables vectored interrupt redirection
// (mtvec[1:0]==01 with an interrupt cause); left undefined, redirects are always direct.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   trap_req        trap request pulse, sampled only while idle
//   trap_epc        faulting PC
//   trap_cause      mcause value, bit31 = interrupt
//   trap_tval       mtval value
//   mret_req        mret request pulse, sampled only while idle (trap wins a tie)
//   mstatus         current mstatus from the register file
//   csr_rdata       register-file read data, combinational from csr_raddr
//   csr_raddr       register-file read address
//   csr_w           register-file write enable
//   csr_waddr       register-file write address
//   csr_wdata       register-file write data
//   csr_wsc_mode    write/set/clear mode, always 01 (plain write)
//   busy            sequencer active, pipeline holds
//   redirect_valid  one-cycle PC redirect strobe
//   redirect_pc     redirect target, valid with redirect_valid
module csr_trap_seq #(
  parameter logic [11:0] MSTATUS_ADDR = 12'h300,
  parameter logic [11:0] MTVEC_ADDR   = 12'h305,
  parameter logic [11:0] MEPC_ADDR    = 12'h341,
  parameter logic [11:0] MCAUSE_ADDR  = 12'h342,
  parameter logic [11:0] MTVAL_ADDR   = 12'h343
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_req,
  input  logic [31:0] trap_epc,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_tval,
  input  logic        mret_req,
  input  logic [31:0] mstatus,
  input  logic [31:0] csr_rdata,
  output logic [11:0] csr_raddr,
  output logic        csr_w,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic [1:0]  csr_wsc_mode,
  output logic        busy,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  typedef enum logic [2:0] {
    IDLE,
    W_MEPC,
    W_MCAUSE,
    W_MTVAL,
    W_MSTATUS,
    R_MTVEC,
    R_MSTATUS_RET,
    R_MEPC
  } state_e;

  state_e      state_q;
  logic [31:0] cause_q;
  logic [31:0] tval_q;
  logic [31:0] mstatus_snap_q;
  logic        csr_w_q;
  logic [11:0] csr_waddr_q;
  logic [31:0] csr_wdata_q;
  logic [1:0]  csr_wsc_mode_q;
  logic        busy_q;
  logic        redirect_valid_q;

  // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= M.
  function automatic logic [31:0] trap_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r         = s;
    r[7]      = s[3];
    r[3]      = 1'b0;
    r[12:11]  = 2'b11;
    return r;
  endfunction

  // mret: MIE <= MPIE, MPIE <= 1, MPP stays M (only M-mode exists here).
  function automatic logic [31:0] mret_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r         = s;
    r[3]      = s[7];
    r[7]      = 1'b1;
    r[12:11]  = 2'b11;
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      cause_q          <= '0;
      tval_q           <= '0;
      mstatus_snap_q   <= '0;
      csr_w_q          <= 1'b0;
      csr_waddr_q      <= '0;
      csr_wdata_q      <= '0;
      csr_wsc_mode_q   <= 2'b00;
      busy_q           <= 1'b0;
      redirect_valid_q <= 1'b0;
    end else begin
      // Write/redirect strobes are one state long; each arm re-asserts as needed.
      csr_wsc_mode_q   <= 2'b01;
      csr_w_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (trap_req) begin
            cause_q        <= trap_cause;
            tval_q         <= trap_tval;
            mstatus_snap_q <= mstatus;
            state_q        <= W_MEPC;
            csr_w_q        <= 1'b1;
            csr_waddr_q    <= MEPC_ADDR;
            csr_wdata_q    <= {trap_epc[31:2], 2'b00};
            busy_q         <= 1'b1;
          end else if (mret_req) begin
            state_q        <= R_MSTATUS_RET;
            csr_w_q        <= 1'b1;
            csr_waddr_q    <= MSTATUS_ADDR;
            csr_wdata_q    <= mret_mstatus(mstatus);
            busy_q         <= 1'b1;
          end
        end
        W_MEPC: begin
          state_q     <= W_MCAUSE;
          csr_w_q     <= 1'b1;
          csr_waddr_q <= MCAUSE_ADDR;
          csr_wdata_q <= cause_q;
        end
        W_MCAUSE: begin
          state_q     <= W_MTVAL;
          csr_w_q     <= 1'b1;
          csr_waddr_q <= MTVAL_ADDR;
          csr_wdata_q <= tval_q;
        end
        W_MTVAL: begin
          state_q     <= W_MSTATUS;
          csr_w_q     <= 1'b1;
          csr_waddr_q <= MSTATUS_ADDR;
          csr_wdata_q <= trap_mstatus(mstatus_snap_q);
        end
        W_MSTATUS: begin
          state_q          <= R_MTVEC;
          redirect_valid_q <= 1'b1;
        end
        R_MTVEC: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        R_MSTATUS_RET: begin
          state_q          <= R_MEPC;
          redirect_valid_q <= 1'b1;
        end
        R_MEPC: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Read address follows the state so the register file answers in the same cycle.
  always_comb begin
    csr_raddr = MSTATUS_ADDR;
    case (state_q)
      R_MTVEC: csr_raddr = MTVEC_ADDR;
      R_MEPC:  csr_raddr = MEPC_ADDR;
      default: csr_raddr = MSTATUS_ADDR;
    endcase
  end

  // The target comes from a combinational read in the redirect state itself, so
  // it cannot be flopped without adding a cycle; it is forced to zero whenever
  // the registered strobe is low, which also gives it a zero reset value.
  logic [31:0] target;
  logic        unused_bits;

`ifdef CSR_TRAP_VECTORED_EN
  always_comb begin
    target = {csr_rdata[31:2], 2'b00};
    if (state_q == R_MTVEC && csr_rdata[1:0] == 2'b01 && cause_q[31])
      target = {csr_rdata[31:2], 2'b00} + {cause_q[29:0], 2'b00};
  end
  assign unused_bits = ^{trap_epc[1:0], cause_q[30]};
`else
  assign target      = {csr_rdata[31:2], 2'b00};
  assign unused_bits = ^{trap_epc[1:0], csr_rdata[1:0]};
`endif

  assign redirect_pc    = redirect_valid_q ? target : 32'h0;
  assign redirect_valid = redirect_valid_q;
  assign csr_w          = csr_w_q;
  assign csr_waddr      = csr_waddr_q;
  assign csr_wdata      = csr_wdata_q;
  assign csr_wsc_mode   = csr_wsc_mode_q;
  assign busy           = busy_q;

endmodule
